gate_checker: RTL and testbench

GATE_CHECKER -- requirements
Module: gate_checker

---
 rtl/gate_checker.sv | 159 +++++++++++++++
 tb/tb_gate_checker.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/gate_checker.sv
// gate_checker: sweeps the four {a,b} input vectors into a 2-input gate under
// test, waits SETTLE cycles per vector, compares dut_y against the expected
// truth table and reports mismatch count, mismatch bitmap and pass/fail.
module gate_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic       dut_y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       bad_sel,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec
);

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  ab_q, ab_d;
  logic [2:0]  err_q, err_d;
  logic [3:0]  fail_q, fail_d;
  logic        pass_q, pass_d;
  logic        bad_q, bad_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Expected gate output for a latched code and stimulus vector {a,b}.
  function automatic logic exp_out(input logic [2:0] sel, input logic [1:0] ab);
    logic y;
    case (sel)
      3'd0:    y = ab[1] & ab[0];
      3'd1:    y = ab[1] | ab[0];
      3'd2:    y = ab[1] ^ ab[0];
      3'd3:    y = ~(ab[1] & ab[0]);
      3'd4:    y = ~(ab[1] | ab[0]);
      3'd5:    y = ~(ab[1] ^ ab[0]);
      default: y = 1'b0;
    endcase
    return y;
  endfunction

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    ab_d    = ab_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    bad_d   = bad_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d  = gate_sel;
          err_d  = 3'd0;
          fail_d = 4'd0;
          pass_d = 1'b0;
          bad_d  = 1'b0;
          ab_d   = 2'b00;
          cnt_d  = RELOAD;
          if (gate_sel > 3'd5) begin
            // Reserved code: report immediately without driving any vector.
            bad_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_SAMPLE: begin
        if ((dut_y != exp_out(sel_q, ab_q)) && (err_q < 3'd4)) begin
          err_d        = err_q + 3'd1;
          fail_d[ab_q] = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (ab_q == 2'b11) begin
          // Verdict uses the count including this final sample.
          pass_d  = (err_d == 3'd0) && !bad_q;
          state_d = ST_DONE;
        end else begin
          ab_d    = ab_q + 2'd1;
          cnt_d   = RELOAD;
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_WAIT) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 3'd0;
      cnt_q   <= 4'd0;
      ab_q    <= 2'b00;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
      pass_q  <= 1'b0;
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ab_q    <= ab_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      bad_q   <= bad_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a        = ab_q[1];
  assign b        = ab_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign bad_sel  = bad_q;
  assign err_cnt  = err_q;
  assign fail_vec = fail_q;

endmodule

// File: tb/tb_gate_checker.sv
// Directed testbench for gate_checker (SETTLE=2) with a behavioural gate on dut_y.
module tb_gate_checker;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] gate_sel;
  logic       dut_y;
  logic       a, b, busy, done, pass, bad_sel;
  logic [2:0] err_cnt;
  logic [3:0] fail_vec;
  int         dut_mode;
  int         n_tests;
  int         n_fail;

  gate_checker #(.SETTLE(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel), .dut_y(dut_y),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass), .bad_sel(bad_sel),
    .err_cnt(err_cnt), .fail_vec(fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate under test: 0..5 = AND,OR,XOR,NAND,NOR,XNOR; 6 = tied 0; 7 = tied 1.
  always_comb begin
    case (dut_mode)
      0:       dut_y = a & b;
      1:       dut_y = a | b;
      2:       dut_y = a ^ b;
      3:       dut_y = ~(a & b);
      4:       dut_y = ~(a | b);
      5:       dut_y = ~(a ^ b);
      6:       dut_y = 1'b0;
      7:       dut_y = 1'b1;
      default: dut_y = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full sweep with hand-computed expectations.
  task automatic sweep(input string tag, input logic [2:0] sel, input int mode,
                       input logic [2:0] e_err, input logic [3:0] e_fail,
                       input logic e_pass, input logic e_bad, input int e_lat,
                       input int e_busy, input logic [1:0] e_ab);
    int  lat;
    int  busy_n;
    int  ab_n[4];
    bit  seen;
    lat = 0; busy_n = 0; seen = 0;
    for (int k = 0; k < 4; k++) ab_n[k] = 0;
    @(negedge clk);
    gate_sel = sel; dut_mode = mode; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    gate_sel = ~sel;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (busy) begin
        busy_n++;
        ab_n[{a, b}]++;
      end
      if (done) begin
        seen = 1;
        lat = i;
      end
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(e_lat));
    check({tag, " err_cnt"}, 32'(err_cnt), 32'(e_err));
    check({tag, " fail_vec"}, 32'(fail_vec), 32'(e_fail));
    check({tag, " pass"}, 32'(pass), 32'(e_pass));
    check({tag, " bad_sel"}, 32'(bad_sel), 32'(e_bad));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(e_busy));
    check({tag, " ab_final"}, 32'({a, b}), 32'(e_ab));
    if (e_busy != 0) begin
      for (int k = 0; k < 4; k++) check({tag, " vec_window"}, 32'(ab_n[k]), 32'd3);
    end
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, " pass_hold"}, 32'(pass), 32'(e_pass));
    check({tag, " err_hold"}, 32'(err_cnt), 32'(e_err));
  endtask

  initial begin
    int  done_n;
    bit  seen;
    n_tests = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; gate_sel = 3'd0; dut_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'({a, b, busy, done, pass, bad_sel, err_cnt, fail_vec}), 32'd0);
    rst = 1'b0;

    sweep("or_ok",      3'd1, 1, 3'd0, 4'b0000, 1'b1, 1'b0, 13, 12, 2'b11);
    sweep("and_vs_or",  3'd0, 1, 3'd2, 4'b0110, 1'b0, 1'b0, 13, 12, 2'b11);
    sweep("nand_tie0",  3'd3, 6, 3'd3, 4'b0111, 1'b0, 1'b0, 13, 12, 2'b11);
    sweep("nor_tie1",   3'd4, 7, 3'd3, 4'b1110, 1'b0, 1'b0, 13, 12, 2'b11);
    sweep("xor_vs_xnr", 3'd2, 5, 3'd4, 4'b1111, 1'b0, 1'b0, 13, 12, 2'b11);
    sweep("xnor_ok",    3'd5, 5, 3'd0, 4'b0000, 1'b1, 1'b0, 13, 12, 2'b11);
    sweep("rsvd7",      3'd7, 1, 3'd0, 4'b0000, 1'b0, 1'b1, 1, 0, 2'b00);

    // Reset during the second WAIT window aborts the sweep.
    @(negedge clk);
    gate_sel = 3'd2; dut_mode = 2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_in_wait2", 32'({busy, a, b}), 32'b101);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_reset_vals", 32'({a, b, busy, done, pass, bad_sel, err_cnt, fail_vec}), 32'd0);
    done_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("abort_no_done", 32'(done_n), 32'd0);
    sweep("xor_after_rst", 3'd2, 2, 3'd0, 4'b0000, 1'b1, 1'b0, 13, 12, 2'b11);

    // Start held high across a whole sweep and its DONE cycle.
    @(negedge clk);
    gate_sel = 3'd1; dut_mode = 1; start = 1'b1;
    done_n = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        done_n++;
        seen = 1;
      end
    end
    check("hold_one_done", 32'(done_n), 32'd1);
    check("hold_pass", 32'(pass), 32'd1);
    @(negedge clk);
    check("hold_idle_after_done", 32'({busy, done}), 32'b00);
    @(negedge clk);
    check("hold_restart", 32'(busy), 32'd1);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("hold_second_done", 32'(seen), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
